// File: rtl/snake_pkg.sv
// Shared definitions for the board front-end: button indices and the
// per-channel debounce state encoding.
package snake_pkg;

    // Button channel indices on the key/key_level buses
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_START = 4;
    localparam int KEY_BACK  = 5;

    // Debounce FSM: two stable states, each with a "waiting to change" state
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter, debounce FSM
// and a registered single-cycle press pulse. Input is already pressed=1.
module key_debounce_ch
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic pixel_clk,
    input  logic sys_rst,
    input  logic pressed,
    output logic key,
    output logic key_level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1, s2;
    db_state_e        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             key_nx, level_nx;

    // Bring the asynchronous pin into the pixel_clk domain; only s2 is used
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pressed;
            s2 <= s1;
        end
    end

    // State, counter and output registers
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            key       <= 1'b0;
            key_level <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            key       <= key_nx;
            key_level <= level_nx;
        end
    end

    // Next-state logic: a level change is accepted only after the counter
    // sees the new level held for the full window; any reversal restarts it
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        key_nx   = 1'b0;
        level_nx = key_level;
        case (state)
            IDLE: begin
                if (s2) begin
                    state_nx = PRESS_WAIT;
                    cnt_nx   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                    key_nx   = 1'b1;
                    level_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_nx = RELEASE_WAIT;
                    cnt_nx   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    // Release glitch: back to held, never re-pulse
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    level_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_pulse_gen.sv
// Push-button front end: normalises pin polarity and runs one independent
// debounce channel per button, producing press pulses and held levels.
module key_pulse_gen
    import snake_pkg::*;
#(
    parameter int N_KEYS          = 6,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic              pixel_clk,
    input  logic              sys_rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_level
);

    logic [N_KEYS-1:0] pressed;

    // Everything downstream sees pressed as 1 regardless of board wiring
    assign pressed = KEY_ACTIVE_LOW ? ~key_raw : key_raw;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .pixel_clk (pixel_clk),
            .sys_rst   (sys_rst),
            .pressed   (pressed[i]),
            .key       (key[i]),
            .key_level (key_level[i])
        );
    end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: an active-low and an active-high instance driven
// side by side, checked every cycle against a run-length debounce model.
module tb_key_pulse_gen;

    localparam int N = 6;
    localparam int D = 4;
    localparam int W = 3;

    logic         pixel_clk = 1'b0;
    logic         sys_rst   = 1'b1;
    logic [N-1:0] raw_lo    = '1;
    logic [N-1:0] raw_hi    = '1;
    logic [N-1:0] key_lo, lvl_lo, key_hi, lvl_hi;

    key_pulse_gen #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .CNT_W(W), .KEY_ACTIVE_LOW(1'b1)) dut_lo (
        .pixel_clk (pixel_clk),
        .sys_rst   (sys_rst),
        .key_raw   (raw_lo),
        .key       (key_lo),
        .key_level (lvl_lo)
    );

    key_pulse_gen #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .CNT_W(W), .KEY_ACTIVE_LOW(1'b0)) dut_hi (
        .pixel_clk (pixel_clk),
        .sys_rst   (sys_rst),
        .key_raw   (raw_hi),
        .key       (key_hi),
        .key_level (lvl_hi)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: synchroniser as a 2-deep delay, then a level that flips once
    // D+1 consecutive synchronised samples disagree with it.
    logic [N-1:0] m_s1 [2];
    logic [N-1:0] m_s2 [2];
    logic [N-1:0] m_lvl[2];
    logic [N-1:0] m_key[2];
    int           m_run[2][N];

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_s1[d] = '0; m_s2[d] = '0; m_lvl[d] = '0; m_key[d] = '0;
            for (int c = 0; c < N; c++) m_run[d][c] = 0;
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] p;
        for (int d = 0; d < 2; d++) begin
            p = (d == 0) ? ~raw_lo : raw_hi;
            m_key[d] = '0;
            for (int c = 0; c < N; c++) begin
                if (m_s2[d][c] != m_lvl[d][c]) m_run[d][c]++;
                else                            m_run[d][c] = 0;
                if (m_run[d][c] == D + 1) begin
                    m_lvl[d][c] = ~m_lvl[d][c];
                    m_run[d][c] = 0;
                    m_key[d][c] = m_lvl[d][c];
                end
            end
            m_s2[d] = m_s1[d];
            m_s1[d] = p;
        end
    endtask

    // One clock: inputs set at the falling edge, outputs checked 1 after rise
    task automatic cycle(input logic [N-1:0] lo, input logic [N-1:0] hi);
        raw_lo = lo;
        raw_hi = hi;
        @(posedge pixel_clk);
        if (sys_rst) model_reset();
        else         model_edge();
        #1;
        chk("key_lo", key_lo, m_key[0]);
        chk("lvl_lo", lvl_lo, m_lvl[0]);
        chk("key_hi", key_hi, m_key[1]);
        chk("lvl_hi", lvl_hi, m_lvl[1]);
        @(negedge pixel_clk);
    endtask

    initial begin
        int           pc;
        int           pr;
        logic [N-1:0] lo_st, hi_st;

        model_reset();
        @(negedge pixel_clk);
        for (int i = 0; i < 3; i++) cycle('1, '1);
        chk("rst_key", key_lo | key_hi, '0);
        sys_rst = 1'b0;

        // Clean press on ch4 (lo); hi instance sees all keys pressed from now
        for (int i = 0; i < 20; i++) begin
            cycle(6'b101111, '1);
            chk("t1_pulse", key_lo, (i == 6) ? 6'b010000 : 6'b000000);
            chk("t6_pulse", key_hi, (i == 6) ? 6'b111111 : 6'b000000);
        end
        for (int i = 0; i < 10; i++) begin
            cycle('1, '1);
            chk("t1_lvl", lvl_lo, (i < 6) ? 6'b010000 : 6'b000000);
        end
        chk("t6_lvl", lvl_hi, 6'b111111);

        // Bounce on ch0, then a genuine press
        pc = 0;
        for (int i = 0; i < 3; i++) begin cycle(6'b111110, '1); pc += key_lo[0]; end
        cycle('1, '1); pc += key_lo[0];
        for (int i = 0; i < 2; i++) begin cycle(6'b111110, '1); pc += key_lo[0]; end
        for (int i = 0; i < 8; i++) begin cycle('1, '1); pc += key_lo[0] | lvl_lo[0]; end
        chk("t2_bounce", N'(pc), '0);
        pc = 0;
        for (int i = 0; i < 10; i++) begin cycle(6'b111110, '1); pc += key_lo[0]; end
        for (int i = 0; i < 10; i++) begin cycle('1, '1); pc += key_lo[0]; end
        chk("t2_pulses", N'(pc), N'(1));

        // Simultaneous ch0+ch1
        for (int i = 0; i < 12; i++) begin
            cycle(6'b111100, '1);
            chk("t3_pulse", key_lo, (i == 6) ? 6'b000011 : 6'b000000);
        end
        for (int i = 0; i < 10; i++) cycle('1, '1);

        // Release glitch on ch5
        pc = 0;
        for (int i = 0; i < 10; i++)  begin cycle(6'b011111, '1); pc += key_lo[5]; end
        for (int i = 0; i < 2; i++)   begin cycle(6'b111111, '1); pc += key_lo[5]; end
        for (int i = 0; i < 100; i++) begin cycle(6'b011111, '1); pc += key_lo[5]; end
        chk("t4_pulses", N'(pc), N'(1));
        chk("t4_lvl", lvl_lo, 6'b100000);
        for (int i = 0; i < 10; i++) cycle('1, '1);

        // Reset while ch2 is mid-debounce, button held through it
        for (int i = 0; i < 5; i++) cycle(6'b111011, '1);
        #2 sys_rst = 1'b1;
        #1 model_reset();
        chk("t5_rst_key", key_lo | key_hi, '0);
        chk("t5_rst_lvl", lvl_lo | lvl_hi, '0);
        @(negedge pixel_clk);
        for (int i = 0; i < 2; i++) cycle(6'b111011, '1);
        sys_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(6'b111011, '1);
            chk("t5_pulse", key_lo, (i == 6) ? 6'b000100 : 6'b000000);
        end

        // Random segments: per-bit flip rate varies from bouncy to calm
        lo_st = raw_lo;
        hi_st = raw_hi;
        for (int s = 0; s < 30; s++) begin
            pr = (s % 3 == 0) ? 1 : ((s % 3 == 1) ? 4 : 14);
            if ($urandom_range(0, 7) == 0) begin
                sys_rst = 1'b1;
                cycle(lo_st, hi_st);
                sys_rst = 1'b0;
            end
            for (int i = 0; i < 100; i++) begin
                for (int b = 0; b < N; b++) begin
                    if ($urandom_range(0, pr) == 0) lo_st[b] = ~lo_st[b];
                    if ($urandom_range(0, pr) == 0) hi_st[b] = ~hi_st[b];
                end
                cycle(lo_st, hi_st);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
